reg_file_sb: RTL and testbench

Parametrised multi-write-port register file with an integrated busy-bit scoreboard and a self-clearing reset sequence. It replaces the single-write-port, fixed 32x32 register file in the processor datapath. It serves pipelined cores with two writeback sources, for example ALU and load. Decode reads operands and hazard status in the same cycle.

---
 rtl/reg_file_sb.sv | 98 +++++++++
 tb/tb_reg_file_sb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: dual-write-port register file with busy-bit scoreboard and self-clearing init sequence.
// Optional same-cycle write forwarding to the read ports is compiled in when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   adr1,
    input  logic [AW-1:0]   adr2,
    output logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] rs2,
    output logic            busy1,
    output logic            busy2,
    input  logic            wr0_en,
    input  logic [AW-1:0]   wr0_adr,
    input  logic [XLEN-1:0] wr0_data,
    input  logic            wr1_en,
    input  logic [AW-1:0]   wr1_adr,
    input  logic [XLEN-1:0] wr1_data,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_adr,
    output logic            ready
);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    cnt;
    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy, busy_nxt;
    logic             zr, run;
    logic             wr0_ok, wr1_ok, iss_ok;
    logic [XLEN-1:0]  rd1, rd2;
    logic             clr1, clr2;

    assign zr     = (ZERO_REG != 0);
    assign run    = (state == RUN);
    assign wr0_ok = wr0_en && !(zr && wr0_adr == '0);
    assign wr1_ok = wr1_en && !(zr && wr1_adr == '0);
    assign iss_ok = iss_en && !(zr && iss_adr == '0);
    assign ready  = run;

    // INIT walks cnt across every register once, then hands over to RUN
    always_comb state_nxt = (state == INIT && cnt == AW'(NREGS - 1)) ? RUN : state;

    // Completing writes clear their busy bit; a same-cycle issue to that register wins
    always_comb begin
        busy_nxt = busy;
        if (wr0_ok) busy_nxt[wr0_adr] = 1'b0;
        if (wr1_ok) busy_nxt[wr1_adr] = 1'b0;
        if (iss_ok) busy_nxt[iss_adr] = 1'b1;
    end

    // State, clear sequence, register writes (wr1 last so it wins) and scoreboard update
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            busy  <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                regs[cnt] <= '0;
                cnt       <= cnt + 1'b1;
            end else begin
                if (wr0_ok) regs[wr0_adr] <= wr0_data;
                if (wr1_ok) regs[wr1_adr] <= wr1_data;
                busy <= busy_nxt;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle write data and hide busy bits that this edge is about to clear
    always_comb begin
        rd1  = (wr1_ok && wr1_adr == adr1) ? wr1_data :
               (wr0_ok && wr0_adr == adr1) ? wr0_data : regs[adr1];
        rd2  = (wr1_ok && wr1_adr == adr2) ? wr1_data :
               (wr0_ok && wr0_adr == adr2) ? wr0_data : regs[adr2];
        clr1 = ((wr0_ok && wr0_adr == adr1) || (wr1_ok && wr1_adr == adr1)) && !(iss_ok && iss_adr == adr1);
        clr2 = ((wr0_ok && wr0_adr == adr2) || (wr1_ok && wr1_adr == adr2)) && !(iss_ok && iss_adr == adr2);
    end
`else
    assign rd1  = regs[adr1];
    assign rd2  = regs[adr2];
    assign clr1 = 1'b0;
    assign clr2 = 1'b0;
`endif

    assign rs1   = (run && !(zr && adr1 == '0)) ? rd1 : '0;
    assign rs2   = (run && !(zr && adr2 == '0)) ? rd2 : '0;
    assign busy1 = run && busy[adr1] && !clr1;
    assign busy2 = run && busy[adr2] && !clr2;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and random checks of reg_file_sb against an array-level reference model.
module tb_reg_file_sb;

    logic        clk = 0;
    logic        rst = 1;
    logic [4:0]  adr1 = 0, adr2 = 0, wr0_adr = 0, wr1_adr = 0, iss_adr = 0;
    logic [31:0] wr0_data = 0, wr1_data = 0;
    logic        wr0_en = 0, wr1_en = 0, iss_en = 0;
    logic [31:0] rs1, rs2;
    logic        busy1, busy2, ready;

    int nchk = 0, nfail = 0;

    logic [31:0] mreg [32];
    bit          mbusy [32];
    int          init_left = 32;
    bit          known = 0;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .adr1(adr1), .adr2(adr2), .rs1(rs1), .rs2(rs2),
        .busy1(busy1), .busy2(busy2),
        .wr0_en(wr0_en), .wr0_adr(wr0_adr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_adr(wr1_adr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_adr(iss_adr), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (init_left != 0 || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (wr1_en && wr1_adr == a) return wr1_data;
        if (wr0_en && wr0_adr == a) return wr0_data;
`endif
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (init_left != 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (((wr0_en && wr0_adr == a) || (wr1_en && wr1_adr == a)) && !(iss_en && iss_adr == a)) return 1'b0;
`endif
        return mbusy[a];
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s.%s: got %0h expected %0h", tag, what, got, exp);
        end
    endtask

    task automatic chk(input string tag);
        if (!known) return;
        cmp(tag, "ready", {31'b0, ready}, {31'b0, init_left == 0});
        cmp(tag, "rs1", rs1, exp_rd(adr1));
        cmp(tag, "rs2", rs2, exp_rd(adr2));
        cmp(tag, "busy1", {31'b0, busy1}, {31'b0, exp_busy(adr1)});
        cmp(tag, "busy2", {31'b0, busy2}, {31'b0, exp_busy(adr2)});
    endtask

    task automatic model_edge();
        if (rst) begin
            known = 1;
            init_left = 32;
            for (int i = 0; i < 32; i++) begin
                mreg[i] = 0;
                mbusy[i] = 0;
            end
        end else if (init_left > 0) begin
            init_left--;
        end else begin
            if (wr0_en && wr0_adr != 0) mreg[wr0_adr] = wr0_data;
            if (wr1_en && wr1_adr != 0) mreg[wr1_adr] = wr1_data;
            if (wr0_en) mbusy[wr0_adr] = 0;
            if (wr1_en) mbusy[wr1_adr] = 0;
            if (iss_en && iss_adr != 0) mbusy[iss_adr] = 1;
        end
    endtask

    task automatic step(input string tag);
        #2;
        chk(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr0_en = 0;
        wr1_en = 0;
        iss_en = 0;
        rst = 0;
    endtask

    task automatic rand_inputs(input bit allow_rst);
        adr1 = 5'($urandom);
        adr2 = 5'($urandom);
        wr0_en = 1'($urandom);
        wr1_en = 1'($urandom);
        iss_en = 1'($urandom);
        wr0_adr = 5'($urandom_range(0, 7));
        wr1_adr = 5'($urandom_range(0, 7));
        iss_adr = 5'($urandom_range(0, 7));
        adr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : adr1;
        wr0_data = $urandom;
        wr1_data = $urandom;
        rst = allow_rst && ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        int cyc;
        step("reset");
        rst = 0;
        wr0_en = 1;
        wr0_adr = 5;
        wr0_data = 32'h12345678;
        adr1 = 5;
        step("init_wr_x5");
        idle();
        cyc = 1;
        while (!ready && cyc < 100) begin
            step("init");
            cyc++;
        end
        cmp("init_len", "cycles", cyc, 32);
        for (int i = 0; i < 32; i++) begin
            adr1 = 5'(i);
            adr2 = 5'(31 - i);
            step("read_zero");
        end
        cmp("x5_lost", "rs1", exp_rd(5), 32'h0);

        wr0_en = 1; wr0_adr = 7; wr0_data = 32'h1111;
        wr1_en = 1; wr1_adr = 7; wr1_data = 32'h2222;
        adr1 = 7;
        step("dual_wr");
        idle();
        step("dual_rd");
        cmp("dual_x7", "rs1", rs1, 32'h2222);

        wr0_en = 1; wr0_adr = 0; wr0_data = 32'hDEADBEEF;
        iss_en = 1; iss_adr = 0; adr1 = 0;
        step("zero_wr");
        idle();
        step("zero_rd");
        cmp("zero", "rs1", rs1, 32'h0);
        cmp("zero", "busy1", {31'b0, busy1}, 32'h0);

        adr1 = 3; adr2 = 3;
        iss_en = 1; iss_adr = 3;
        step("sb_iss");
        idle();
        step("sb_set");
        cmp("sb_set", "busy1", {31'b0, busy1}, 32'h1);
        wr1_en = 1; wr1_adr = 3; wr1_data = 32'h55;
        step("sb_wr1");
        idle();
        step("sb_clr");
        cmp("sb_clr", "busy1", {31'b0, busy1}, 32'h0);
        iss_en = 1; iss_adr = 3; wr0_en = 1; wr0_adr = 3; wr0_data = 32'h66;
        step("sb_both");
        idle();
        step("sb_keep");
        cmp("sb_keep", "busy1", {31'b0, busy1}, 32'h1);

        adr1 = 9;
        wr0_en = 1; wr0_adr = 9; wr0_data = 32'hCAFE;
        #2;
`ifdef REGFILE_BYPASS_EN
        cmp("bypass", "rs1_same", rs1, 32'hCAFE);
`else
        cmp("bypass", "rs1_same", rs1, 32'h0);
`endif
        step("bypass_wr");
        idle();
        step("bypass_next");
        cmp("bypass", "rs1_next", rs1, 32'hCAFE);

        for (int i = 0; i < 400; i++) begin
            rand_inputs(1);
            step("random");
        end
        idle();
        for (int i = 0; i < 40; i++) step("drain");

        wr0_en = 1; wr0_adr = 1; wr0_data = 32'hA5A5A5A5;
        step("mid_load");
        idle();
        adr1 = 1;
        step("mid_rd");
        cmp("mid_load", "rs1", rs1, 32'hA5A5A5A5);
        rst = 1;
        step("mid_rst");
        rst = 0;
        #2;
        cmp("mid_rst", "ready", {31'b0, ready}, 32'h0);
        for (int i = 0; i < 32; i++) step("mid_init");
        step("mid_after");
        cmp("mid_after", "rs1", rs1, 32'h0);
        cmp("mid_after", "ready", {31'b0, ready}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
